// File: rtl/vlc_table_arbiter_pkg.sv
// Shared defines for the VLC table arbiter: default widths, table region bases, FSM state type.
package vlc_table_arbiter_pkg;

    localparam int unsigned VLC_ADDR_W = 10;
    localparam int unsigned VLC_DATA_W = 16;

    // Region start addresses; each requester adds its own code offset.
    localparam logic [VLC_ADDR_W-1:0] VLC_B2_BASE  = 10'h000;
    localparam logic [VLC_ADDR_W-1:0] VLC_B3_BASE  = 10'h040;
    localparam logic [VLC_ADDR_W-1:0] VLC_B4_BASE  = 10'h0C0;
    localparam logic [VLC_ADDR_W-1:0] VLC_B14_BASE = 10'h1C0;
    localparam logic [VLC_ADDR_W-1:0] VLC_B15_BASE = 10'h2C0;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/vlc_table_arbiter_rr_pick.sv
// Round-robin picker: one-hot select of the first request at or after i_ptr, wrapping.
module rr_pick
    import vlc_table_arbiter_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_sel,
    output logic               o_valid
);

    int unsigned w_idx;

    always_comb begin
        o_sel   = '0;
        o_valid = 1'b0;
        w_idx   = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_idx = (32'(i_ptr) + i) % NUM_REQ;
            if (!o_valid && i_req[IDX_W'(w_idx)]) begin
                o_sel[IDX_W'(w_idx)] = 1'b1;
                o_valid              = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vlc_table_arbiter.sv
// Arbitrates one shared VLC lookup table among NUM_REQ decoders, with round-robin
// grant, owner-muxed read port, and forced release after MAX_HOLD owned cycles.
module vlc_table_arbiter
    import vlc_table_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned ADDR_W   = VLC_ADDR_W,
    parameter int unsigned DATA_W   = VLC_DATA_W,
    parameter int unsigned MAX_HOLD = 32
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic [NUM_REQ-1:0]        Req_I,
    input  logic [NUM_REQ-1:0]        Done_I,
    input  logic [NUM_REQ-1:0]        Rd_En_I,
    input  logic [NUM_REQ*ADDR_W-1:0] Addr_I,
    output logic [NUM_REQ-1:0]        Grant_O,
    output logic [NUM_REQ-1:0]        Data_Valid_O,
    output logic [DATA_W-1:0]         Data_O,
    output logic [NUM_REQ-1:0]        Abort_O,
    output logic                      Table_En_O,
    output logic [ADDR_W-1:0]         Table_Addr_O,
    input  logic [DATA_W-1:0]         Table_Data_I
);

    localparam int unsigned       IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned       HOLD_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_REQ - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    arb_state_e          r_state, w_state_nxt;
    logic [IDX_W-1:0]    r_owner, w_owner_nxt;
    logic [IDX_W-1:0]    r_rr_ptr, w_rr_ptr_nxt;
    logic [HOLD_W-1:0]   r_hold, w_hold_nxt;
    logic [NUM_REQ-1:0]  r_grant, w_grant_nxt;
    logic [NUM_REQ-1:0]  r_data_valid, w_data_valid_nxt;
    logic [NUM_REQ-1:0]  r_abort, w_abort_nxt;

    logic [NUM_REQ-1:0]  w_pick_sel;
    logic                w_pick_valid;
    logic [IDX_W-1:0]    w_pick_idx;
    logic                w_own_req, w_own_done, w_own_rd, w_release;
    logic [ADDR_W-1:0]   w_own_addr;
    logic [IDX_W-1:0]    w_owner_inc;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .i_req   (Req_I),
        .i_ptr   (r_rr_ptr),
        .o_sel   (w_pick_sel),
        .o_valid (w_pick_valid)
    );

    // Select the owner's request lines; non-owner inputs never reach the table.
    always_comb begin
        w_pick_idx = '0;
        w_own_req  = 1'b0;
        w_own_done = 1'b0;
        w_own_rd   = 1'b0;
        w_own_addr = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_pick_sel[i]) begin
                w_pick_idx = IDX_W'(i);
            end
            if (IDX_W'(i) == r_owner) begin
                w_own_req  = Req_I[i];
                w_own_done = Done_I[i];
                w_own_rd   = Rd_En_I[i];
                w_own_addr = Addr_I[i*ADDR_W +: ADDR_W];
            end
        end
    end

    assign w_release   = w_own_done | ~w_own_req;
    assign w_owner_inc = (r_owner == LAST_IDX) ? '0 : r_owner + IDX_W'(1);

    // Next-state and next-output logic; normal release outranks the timeout.
    always_comb begin
        w_state_nxt      = r_state;
        w_owner_nxt      = r_owner;
        w_rr_ptr_nxt     = r_rr_ptr;
        w_hold_nxt       = r_hold;
        w_grant_nxt      = r_grant;
        w_data_valid_nxt = '0;
        w_abort_nxt      = '0;
        case (r_state)
            ST_IDLE: begin
                w_grant_nxt = '0;
                if (w_pick_valid) begin
                    w_state_nxt = ST_OWNED;
                    w_owner_nxt = w_pick_idx;
                    w_grant_nxt = w_pick_sel;
                    w_hold_nxt  = '0;
                end
            end
            ST_OWNED: begin
                w_data_valid_nxt = w_own_rd ? r_grant : '0;
                if (w_release) begin
                    w_state_nxt  = ST_IDLE;
                    w_grant_nxt  = '0;
                    w_rr_ptr_nxt = w_owner_inc;
                end else if (r_hold == HOLD_LAST) begin
                    w_state_nxt  = ST_IDLE;
                    w_grant_nxt  = '0;
                    w_abort_nxt  = r_grant;
                    w_rr_ptr_nxt = w_owner_inc;
                end else begin
                    w_hold_nxt = r_hold + HOLD_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state      <= ST_IDLE;
            r_owner      <= '0;
            r_rr_ptr     <= '0;
            r_hold       <= '0;
            r_grant      <= '0;
            r_data_valid <= '0;
            r_abort      <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_rr_ptr     <= w_rr_ptr_nxt;
            r_hold       <= w_hold_nxt;
            r_grant      <= w_grant_nxt;
            r_data_valid <= w_data_valid_nxt;
            r_abort      <= w_abort_nxt;
        end
    end

    assign Grant_O      = r_grant;
    assign Data_Valid_O = r_data_valid;
    assign Abort_O      = r_abort;
    assign Data_O       = Table_Data_I;
    assign Table_En_O   = (r_state == ST_OWNED) & w_own_rd;
    assign Table_Addr_O = (r_state == ST_OWNED) ? w_own_addr : '0;

endmodule

// File: tb/tb_vlc_table_arbiter.sv
// Directed bench for vlc_table_arbiter: vector table for grant/read path, plus
// hand sequences for round-robin order, timeout, release-vs-timeout and reset.
`timescale 1ns/1ps
module tb_vlc_table_arbiter;

    localparam int unsigned NUM_REQ  = 4;
    localparam int unsigned ADDR_W   = 10;
    localparam int unsigned DATA_W   = 16;
    localparam int unsigned MAX_HOLD = 32;

    logic                      clock;
    logic                      resetn;
    logic [NUM_REQ-1:0]        req, done, rd;
    logic [NUM_REQ*ADDR_W-1:0] addr;
    logic [DATA_W-1:0]         tdata;
    logic [NUM_REQ-1:0]        grant, dv, abort;
    logic [DATA_W-1:0]         data;
    logic                      ten;
    logic [ADDR_W-1:0]         taddr;

    int checks;
    int errors;

    vlc_table_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clock        (clock),
        .resetn       (resetn),
        .Req_I        (req),
        .Done_I       (done),
        .Rd_En_I      (rd),
        .Addr_I       (addr),
        .Grant_O      (grant),
        .Data_Valid_O (dv),
        .Data_O       (data),
        .Abort_O      (abort),
        .Table_En_O   (ten),
        .Table_Addr_O (taddr),
        .Table_Data_I (tdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  done;
        logic [3:0]  rd;
        logic [9:0]  a0;
        logic [9:0]  a2;
        logic [15:0] td;
        logic [3:0]  e_grant;
        logic [3:0]  e_dv;
        logic        e_ten;
        logic [9:0]  e_taddr;
    } vec_t;

    vec_t vec [12];

    function automatic vec_t mk(input logic [3:0] r, input logic [3:0] d, input logic [3:0] re,
                                input logic [9:0] a0, input logic [9:0] a2, input logic [15:0] td,
                                input logic [3:0] eg, input logic [3:0] edv, input logic ete,
                                input logic [9:0] eta);
        vec_t v;
        v.req = r; v.done = d; v.rd = re; v.a0 = a0; v.a2 = a2; v.td = td;
        v.e_grant = eg; v.e_dv = edv; v.e_ten = ete; v.e_taddr = eta;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        resetn = 1'b0;
        req = '0; done = '0; rd = '0; addr = '0; tdata = '0;
        @(negedge clock); #1;
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_dv", 32'(dv), 32'h0);
        check("rst_abort", 32'(abort), 32'h0);
        check("rst_ten", 32'(ten), 32'h0);
        @(negedge clock);
        resetn = 1'b1;
    endtask

    task automatic wait_grant(input logic [3:0] exp, input string name);
        int n;
        n = 0;
        while (grant !== exp && n < 10) begin
            @(negedge clock); #1;
            n++;
        end
        check(name, 32'(grant), 32'(exp));
    endtask

    task automatic run_table();
        vec[0]  = mk(4'b0101, 4'b0000, 4'b0000, 10'h000, 10'h000, 16'h0000, 4'b0000, 4'b0000, 1'b0, 10'h000);
        vec[1]  = mk(4'b0101, 4'b0001, 4'b0001, 10'h055, 10'h000, 16'h0000, 4'b0001, 4'b0000, 1'b1, 10'h055);
        vec[2]  = mk(4'b0101, 4'b0000, 4'b0000, 10'h055, 10'h000, 16'hBEEF, 4'b0000, 4'b0001, 1'b0, 10'h000);
        vec[3]  = mk(4'b0100, 4'b0000, 4'b0101, 10'h3FF, 10'h1A3, 16'h0000, 4'b0100, 4'b0000, 1'b1, 10'h1A3);
        vec[4]  = mk(4'b0100, 4'b0000, 4'b0001, 10'h3FF, 10'h1A3, 16'h1234, 4'b0100, 4'b0100, 1'b0, 10'h000);
        vec[5]  = mk(4'b0000, 4'b0000, 4'b0000, 10'h000, 10'h000, 16'h0000, 4'b0100, 4'b0000, 1'b0, 10'h000);
        vec[6]  = mk(4'b0000, 4'b0000, 4'b0000, 10'h000, 10'h000, 16'h0000, 4'b0000, 4'b0000, 1'b0, 10'h000);
        vec[7]  = mk(4'b0001, 4'b0001, 4'b0000, 10'h000, 10'h000, 16'h0000, 4'b0000, 4'b0000, 1'b0, 10'h000);
        vec[8]  = mk(4'b0001, 4'b0001, 4'b0000, 10'h000, 10'h000, 16'h0000, 4'b0001, 4'b0000, 1'b0, 10'h000);
        vec[9]  = mk(4'b0001, 4'b0000, 4'b0000, 10'h000, 10'h000, 16'h0000, 4'b0000, 4'b0000, 1'b0, 10'h000);
        vec[10] = mk(4'b0000, 4'b0000, 4'b0000, 10'h000, 10'h000, 16'h0000, 4'b0001, 4'b0000, 1'b0, 10'h000);
        vec[11] = mk(4'b0000, 4'b0000, 4'b0000, 10'h000, 10'h000, 16'h0000, 4'b0000, 4'b0000, 1'b0, 10'h000);
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            req   = vec[k].req;
            done  = vec[k].done;
            rd    = vec[k].rd;
            addr  = {10'h155, vec[k].a2, 10'h2AA, vec[k].a0};
            tdata = vec[k].td;
            #1;
            check($sformatf("vec%0d_grant", k), 32'(grant), 32'(vec[k].e_grant));
            check($sformatf("vec%0d_dv", k), 32'(dv), 32'(vec[k].e_dv));
            check($sformatf("vec%0d_abort", k), 32'(abort), 32'h0);
            check($sformatf("vec%0d_ten", k), 32'(ten), 32'(vec[k].e_ten));
            check($sformatf("vec%0d_data", k), 32'(data), 32'(vec[k].td));
            if (vec[k].e_ten) check($sformatf("vec%0d_taddr", k), 32'(taddr), 32'(vec[k].e_taddr));
        end
    endtask

    task automatic seq_round_robin();
        logic [3:0] order [5];
        logic [3:0] prev;
        int n_ten, len, gap, cyc;
        order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
        order[3] = 4'b1000; order[4] = 4'b0001;
        prev = '0; n_ten = 0; len = 0; gap = 0; cyc = 0;
        do_reset();
        req = 4'b1111;
        while (n_ten < 5 && cyc < 60) begin
            @(negedge clock); #1;
            cyc++;
            if (grant != 4'b0000) begin
                if (prev == 4'b0000) begin
                    check($sformatf("rr_order%0d", n_ten), 32'(grant), 32'(order[n_ten]));
                    if (n_ten > 0) check($sformatf("rr_gap%0d", n_ten), 32'(gap), 32'd1);
                    n_ten++;
                    len = 0;
                end
                len++;
                if (len == 3) done = grant;
            end else begin
                if (prev != 4'b0000) begin
                    check("rr_tenure_len", 32'(len), 32'd3);
                    gap = 1;
                end else begin
                    gap++;
                end
                done = '0;
            end
            prev = grant;
        end
        if (n_ten < 5) check("rr_timeout", 32'(n_ten), 32'd5);
        req = '0; done = '0;
    endtask

    task automatic seq_timeout();
        int own, ab_seen;
        do_reset();
        req = 4'b0110;
        @(negedge clock); #1;
        wait_grant(4'b0010, "to_grant1");
        own = 0; ab_seen = 0;
        while (grant == 4'b0010 && own < 40) begin
            own++;
            if (abort != 4'b0000) ab_seen++;
            @(negedge clock); #1;
        end
        check("to_tenure_len", 32'(own), 32'(MAX_HOLD));
        check("to_no_early_abort", 32'(ab_seen), 32'd0);
        check("to_abort", 32'(abort), 32'b0010);
        check("to_idle", 32'(grant), 32'h0);
        @(negedge clock); #1;
        check("to_abort_pulse", 32'(abort), 32'h0);
        check("to_next_grant", 32'(grant), 32'b0100);
    endtask

    task automatic seq_release_vs_timeout();
        do_reset();
        req = 4'b0010;
        @(negedge clock); #1;
        wait_grant(4'b0010, "d31_grant");
        for (int k = 1; k < 32; k++) begin
            @(negedge clock); #1;
        end
        check("d31_still_owned", 32'(grant), 32'b0010);
        done = 4'b0010;
        @(negedge clock); #1;
        check("d31_released", 32'(grant), 32'h0);
        check("d31_no_abort", 32'(abort), 32'h0);
        done = '0;
        @(negedge clock); #1;
        check("d31_regrant", 32'(grant), 32'b0010);
        check("d31_no_abort_late", 32'(abort), 32'h0);
        req = '0;
    endtask

    task automatic seq_mid_reset();
        do_reset();
        req  = 4'b0001;
        rd   = 4'b0001;
        addr = {10'h155, 10'h000, 10'h2AA, 10'h0C0};
        @(negedge clock); #1;
        wait_grant(4'b0001, "mr_grant");
        check("mr_ten", 32'(ten), 32'd1);
        check("mr_taddr", 32'(taddr), 32'h0C0);
        @(negedge clock); #1;
        check("mr_dv_before", 32'(dv), 32'b0001);
        resetn = 1'b0;
        #1;
        check("mr_grant_drop", 32'(grant), 32'h0);
        check("mr_dv_drop", 32'(dv), 32'h0);
        check("mr_ten_drop", 32'(ten), 32'h0);
        @(negedge clock);
        resetn = 1'b1;
        req = 4'b0011;
        rd  = 4'b0011;
        @(negedge clock); #1;
        check("mr_first_grant", 32'(grant), 32'b0001);
        check("mr_no_dv_after", 32'(dv), 32'h0);
        req = '0; rd = '0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        resetn = 1'b0;
        req = '0; done = '0; rd = '0; addr = '0; tdata = '0;
        do_reset();
        run_table();
        seq_round_robin();
        seq_timeout();
        seq_release_vs_timeout();
        seq_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
